// File: rtl/led_blink_coder_pkg.sv
// Shared types and sizing helpers for the LED blink-code display.
// Keeps the FSM and its timer agreed on state encoding and timer width.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Timer bits needed to hold the largest phase length minus one, never below 1.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_blink_coder_timer.sv
// Loadable down-counter that parks at zero; zero flag is straight from the register.
// A load strobe wins over counting.
module blink_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_blink_coder.sv
// Shows a saturated event count on one LED as N blinks followed by a dark gap.
// Count is sampled once per frame in IDLE; led and frame_done are registered.
module led_blink_coder
  import led_blink_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter int ON_CYC  = 4,
  parameter int OFF_CYC = 4,
  parameter int GAP_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] count,
  output logic             led,
  output logic             frame_done
);

  localparam int TW = timer_w(ON_CYC, OFF_CYC, GAP_CYC);
  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYC - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYC - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] blinks_left;
  logic [CNT_W-1:0] blinks_nxt;
  logic [CNT_W-1:0] blinks_dec;
  logic             load;
  logic [TW-1:0]    load_val;
  logic             tmr_zero;

  blink_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (tmr_zero)
  );

  assign blinks_dec = blinks_left - CNT_W'(1);

  // Every state entry reloads the timer, so each phase lasts exactly its length.
  always_comb begin
    state_nxt  = state;
    blinks_nxt = blinks_left;
    load       = 1'b0;
    load_val   = '0;
    case (state)
      IDLE: begin
        if (en) begin
          blinks_nxt = count;
          load       = 1'b1;
          if (count != '0) begin
            state_nxt = ON;
            load_val  = ON_LD;
          end else begin
            state_nxt = GAP;
            load_val  = GAP_LD;
          end
        end
      end
      ON: begin
        if (tmr_zero) begin
          state_nxt = OFF;
          load      = 1'b1;
          load_val  = OFF_LD;
        end
      end
      OFF: begin
        if (tmr_zero) begin
          blinks_nxt = blinks_dec;
          load       = 1'b1;
          if (blinks_dec != '0) begin
            state_nxt = ON;
            load_val  = ON_LD;
          end else begin
            state_nxt = GAP;
            load_val  = GAP_LD;
          end
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // led is registered from the next state so it tracks (state == ON) exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      blinks_left <= '0;
      led         <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      blinks_left <= blinks_nxt;
      led         <= (state_nxt == ON);
      frame_done  <= (state == GAP) && tmr_zero;
    end
  end

endmodule

// File: tb/tb_led_blink_coder.sv
// Scoreboard bench: stimulus pushes hand-written per-cycle led/frame_done patterns,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_led_blink_coder;

  typedef struct packed {
    logic led;
    logic fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] count = 2'd0;
  logic       led;
  logic       frame_done;
  logic       en3 = 1'b0;
  logic [2:0] count3 = 3'd0;
  logic       led3;
  logic       frame_done3;

  exp_t q[$];
  exp_t q3[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  led_blink_coder #(.CNT_W(2), .ON_CYC(2), .OFF_CYC(2), .GAP_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count      (count),
    .led        (led),
    .frame_done (frame_done)
  );

  led_blink_coder #(.CNT_W(3), .ON_CYC(2), .OFF_CYC(2), .GAP_CYC(4)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .en         (en3),
    .count      (count3),
    .led        (led3),
    .frame_done (frame_done3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // l/f are strings of '0'/'1', one character per cycle.
  task automatic push(input string l, input string f, input bit to3);
    exp_t e;
    for (int i = 0; i < l.len(); i++) begin
      e.led = (l[i] == "1");
      e.fd  = (f[i] == "1");
      if (to3) q3.push_back(e);
      else     q.push_back(e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("led", {31'd0, led}, {31'd0, e.led});
      check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      check("led_w3", {31'd0, led3}, {31'd0, e.led});
      check("frame_done_w3", {31'd0, frame_done3}, {31'd0, e.fd});
    end
  end

  initial begin
    #2;
    check("rst_led", {31'd0, led}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    cycles(3);
    rst = 1'b0;

    // Idle with en low.
    push("000000", "000000", 1'b0);
    cycles(6);

    // count=3, en held: two full frames.
    count = 2'd3;
    en    = 1'b1;
    push("01100110011000000", "00000000000000000", 1'b0);
    push("01100110011000000", "10000000000000000", 1'b0);
    cycles(34);

    // count=0: dark frames of 5 cycles.
    count = 2'd0;
    push("00000", "10000", 1'b0);
    push("00000", "10000", 1'b0);
    cycles(10);

    // count=1 sampled, changed to 3 mid-blink: one blink only.
    count = 2'd1;
    push("011000000", "100000000", 1'b0);
    cycles(2);
    count = 2'd3;
    cycles(7);
    push("01100110011000000", "10000000000000000", 1'b0);
    cycles(17);

    // count=2, en dropped during the second blink.
    count = 2'd2;
    push("0110011000000", "1000000000000", 1'b0);
    cycles(6);
    en = 1'b0;
    cycles(7);
    push("000000", "100000", 1'b0);
    cycles(6);

    // Asynchronous reset in the middle of ON.
    count = 2'd3;
    en    = 1'b1;
    @(posedge clk);
    #3;
    check("on_before_rst", {31'd0, led}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_led", {31'd0, led}, 32'd0);
    en = 1'b0;
    cycles(1);
    rst = 1'b0;
    push("00000000", "00000000", 1'b0);
    cycles(8);

    // First edge with en=1 after reset starts a frame.
    count = 2'd1;
    en    = 1'b1;
    push("0110000000", "0000000001", 1'b0);
    cycles(1);
    en = 1'b0;
    cycles(9);

    // Wider count: 7 blinks, 33-cycle frame.
    count3 = 3'd7;
    en3    = 1'b1;
    push("0", "0", 1'b1);
    for (int i = 0; i < 7; i++) push("1100", "0000", 1'b1);
    push("00000", "00001", 1'b1);
    cycles(1);
    en3 = 1'b0;
    cycles(33);

    cycles(2);
    check("q_drain", q.size(), 32'd0);
    check("q3_drain", q3.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_blink_coder.md
# led_blink_coder

Reader side of the saturating event counter: takes the counter's 2-bit saturated count and shows it on one LED as a repeating blink code (N blinks, then a long dark gap). It sits between the PRBS error counter and the board LED pin, so a count of 0–3 can be read by eye. Each frame samples the count once; changes during a frame are ignored until the next frame.

## Interface
- CNT_W, 2, width of the count input; max blinks per frame = 2^CNT_W − 1
- ON_CYC, 4, clk cycles LED is lit per blink (≥1)
- OFF_CYC, 4, clk cycles LED is dark between blinks (≥1)
- GAP_CYC, 16, clk cycles of dark gap ending each frame (≥1)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  allow a new frame to start; sampled only in IDLE
- count  in  CNT_W  saturated count to display, unsigned
- led  out  1  registered LED drive, 1 = lit
- frame_done  out  1  one-cycle pulse at the end of each frame

## Operation
- States: IDLE, ON, OFF, GAP. Reset forces state IDLE, led=0, frame_done=0, blink and timer registers 0. Reset is asynchronous: led falls without waiting for clk, including in the middle of ON.
- IDLE, en=0: stay in IDLE; led=0.
- IDLE, en=1: latch count into blinks_left.
  - count≠0 → ON, timer=ON_CYC−1.
  - count=0 → GAP, timer=GAP_CYC−1. LED stays dark for the whole frame.
- ON: led=1. When timer=0 → OFF, timer=OFF_CYC−1; otherwise decrement the timer.
- OFF: led=0. When timer=0, decrement blinks_left:
  - result≠0 → ON, timer=ON_CYC−1
  - result=0 → GAP, timer=GAP_CYC−1
  - otherwise decrement the timer
- GAP: led=0. When timer=0 → IDLE and frame_done=1 for the next cycle only.
- en deasserted mid-frame: the frame runs to completion, then the block parks in IDLE.
- The count input is read only on the IDLE→ON/GAP transition. Mid-frame changes have no effect.
- Timer width is clog2(max(ON_CYC, OFF_CYC, GAP_CYC)), minimum 1. blinks_left is CNT_W bits. There is no wrap-around: the decrement is never reached with blinks_left=0.

## Timing
- led is a register whose value equals (state==ON), so it has no combinational path from any input.
- Frame length with en held high and count=N is 1 + N·(ON_CYC+OFF_CYC) + GAP_CYC cycles. The 1 is the IDLE sample cycle.
- For N=0 the frame length is 1 + GAP_CYC.
- led rises in the first cycle after the edge that samples en=1 in IDLE.
- frame_done is high during the IDLE cycle that follows GAP. That same cycle samples en for the next frame, so back-to-back frames have no extra idle cycle.
- After rst deasserts, the first edge with en=1 starts a frame.

## Structure
- Shared package `led_blink_pkg` holds:
  - state enum (IDLE, ON, OFF, GAP; 2-bit encoding)
  - timer-width helper function (clog2 of max of three values)
- One sub-module is natural: `blink_timer`, a loadable down-counter with a load value, load strobe and zero flag. The FSM instantiates it once and reloads it on every state entry.
- Total RTL expected: about 150–250 lines.

## Test plan
All cases use ON_CYC=2, OFF_CYC=2, GAP_CYC=4.
- Reset: assert rst mid-ON → led=0 immediately, before the next clk edge. Release rst with en=0 → led stays 0, frame_done never pulses.
- count=3, en=1 held: led pattern after the sample cycle is 11 00 11 00 11 00 0000. frame_done pulses once every 17 cycles, in the IDLE cycle.
- count=0, en=1: led stays 0 throughout. frame_done pulses every 5 cycles.
- count=1 at sample, switched to 3 during ON: exactly one blink in that frame. The next frame shows 3 blinks.
- en dropped during the second blink of count=2: the frame completes (2 blinks, gap, frame_done). The block then stays in IDLE with led=0 until en=1.
- Parameter sweep CNT_W=3, count=7: 7 blinks. Frame length = 1 + 7·4 + 4 = 33 cycles.
